// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier: step states and per-step shifts.
package mul_pkg;

  localparam int MUL_OP_W = 8;
  localparam int MUL_P_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    S_LL,
    S_HL,
    S_LH,
    S_HH,
    DONE
  } state_t;

  localparam logic [3:0] SHIFT_LL = 4'd0;
  localparam logic [3:0] SHIFT_HL = 4'd4;
  localparam logic [3:0] SHIFT_LH = 4'd4;
  localparam logic [3:0] SHIFT_HH = 4'd8;

  function automatic logic [3:0] step_shift(input state_t s);
    case (s)
      S_HL:    return SHIFT_HL;
      S_LH:    return SHIFT_LH;
      S_HH:    return SHIFT_HH;
      default: return SHIFT_LL;
    endcase
  endfunction

endpackage

// File: rtl/CLA.sv
// Carry-lookahead adder: every carry is a flat sum of generate terms gated by the propagate run below it.
module CLA #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout
);

  logic [DATA_WIDTH-1:0] g;
  logic [DATA_WIDTH-1:0] p;
  logic [DATA_WIDTH:0]   c;
  logic                  carry;
  logic                  prop;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c     = '0;
    carry = 1'b0;
    prop  = 1'b0;
    c[0]  = cin;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      carry = g[i];
      prop  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        carry = carry | (prop & g[j]);
        prop  = prop & p[j];
      end
      c[i+1] = carry | (prop & cin);
    end
  end

  assign sum  = p ^ c[DATA_WIDTH-1:0];
  assign cout = c[DATA_WIDTH];

endmodule

// File: rtl/mul4x4.sv
// Combinational 4x4 unsigned multiplier, 8-bit product.
module mul4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'b0, a} * {4'b0, b};

endmodule

// File: rtl/mul8x8_seq.sv
// Sequential 8x8 unsigned multiplier: one mul4x4 shared over four nibble steps, accumulated through a 16-bit CLA.
// Fixed 4-cycle accept-to-valid latency; the result holds in DONE until out_ready, which also admits the next request.
module mul8x8_seq
  import mul_pkg::*;
#(
  parameter int TAG_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_OP_W-1:0] in_a,
  input  logic [MUL_OP_W-1:0] in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MUL_P_W-1:0]  out_p,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);

  state_t              state_q;
  state_t              state_d;
  logic [MUL_OP_W-1:0] a_q;
  logic [MUL_OP_W-1:0] b_q;
  logic [TAG_W-1:0]    tag_q;
  logic [MUL_P_W-1:0]  acc_q;
  logic [MUL_P_W-1:0]  acc_sum;
  logic [MUL_P_W-1:0]  pp_shifted;
  logic [3:0]          nib_a;
  logic [3:0]          nib_b;
  logic [7:0]          pp;
  logic                busy_q;
  logic                accept;
  logic                step;
  logic                cla_cout_unused;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign step     = (state_q == S_LL) || (state_q == S_HL) ||
                    (state_q == S_LH) || (state_q == S_HH);

  always_comb begin
    nib_a = a_q[3:0];
    nib_b = b_q[3:0];
    case (state_q)
      S_HL: nib_a = a_q[7:4];
      S_LH: nib_b = b_q[7:4];
      S_HH: begin
        nib_a = a_q[7:4];
        nib_b = b_q[7:4];
      end
      default: ;
    endcase
  end

  mul4x4 u_mul4x4 (
    .a (nib_a),
    .b (nib_b),
    .p (pp)
  );

  assign pp_shifted = {8'b0, pp} << step_shift(state_q);

  // Carry-out is dropped: the largest 8x8 product still fits in 16 bits.
  CLA #(.DATA_WIDTH(MUL_P_W)) u_cla (
    .a    (acc_q),
    .b    (pp_shifted),
    .cin  (1'b0),
    .sum  (acc_sum),
    .cout (cla_cout_unused)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = S_LL;
      S_LL: state_d = S_HL;
      S_HL: state_d = S_LH;
      S_LH: state_d = S_HH;
      S_HH: state_d = DONE;
      DONE: if (out_ready) state_d = in_valid ? S_LL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        tag_q <= in_tag;
        acc_q <= '0;
      end else if (step) begin
        acc_q <= acc_sum;
      end
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_p     = acc_q;
  assign out_tag   = tag_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul8x8_seq.sv
// Bench for mul8x8_seq: cycle-level queue model checked every falling edge, plus directed literal vectors.
module tb_mul8x8_seq;

  localparam int TAG_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [15:0]      out_p;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_acc = 0;

  typedef struct {
    logic [15:0]      p;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;
  exp_t q[$];

  mul8x8_seq #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each accepted request becomes valid 4 edges after its accept edge and leaves in order.
  logic ov_exp;
  logic ir_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst out_valid", 32'(out_valid), 32'(0));
      check("rst busy", 32'(busy), 32'(0));
      check("rst in_ready", 32'(in_ready), 32'(1));
      check("rst out_p", 32'(out_p), 32'(0));
      check("rst out_tag", 32'(out_tag), 32'(0));
      q.delete();
    end else begin
      ov_exp = 1'b0;
      if (q.size() > 0) ov_exp = (q[0].due <= cyc);
      ir_exp = (q.size() == 0) || (ov_exp && out_ready);
      check("out_valid", 32'(out_valid), 32'(ov_exp));
      check("busy", 32'(busy), 32'(q.size() > 0));
      check("in_ready", 32'(in_ready), 32'(ir_exp));
      if (ov_exp) begin
        check("out_p", 32'(out_p), 32'(q[0].p));
        check("out_tag", 32'(out_tag), 32'(q[0].tag));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && ir_exp) begin
        q.push_back('{16'(in_a) * 16'(in_b), in_tag, cyc + 5});
        n_acc++;
      end
    end
  end

  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] tag,
                         input logic [15:0] exp_p, input int stall, input string nm);
    int  start;
    bit  got;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    out_ready = (stall == 0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) begin
      check({nm, " accept timeout"}, 32'(0), 32'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    start = cyc;
    in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
    end
    check({nm, " valid seen"}, 32'(got), 32'(1));
    check({nm, " latency"}, 32'(cyc - start), 32'(4));
    check({nm, " p"}, 32'(out_p), 32'(exp_p));
    check({nm, " tag"}, 32'(out_tag), 32'(tag));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({nm, " hold valid"}, 32'(out_valid), 32'(1));
      check({nm, " hold p"}, 32'(out_p), 32'(exp_p));
      check({nm, " hold in_ready"}, 32'(in_ready), 32'(0));
    end
    if (stall > 0) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({nm, " idle busy"}, 32'(busy), 32'(0));
    check({nm, " idle valid"}, 32'(out_valid), 32'(0));
  endtask

  task automatic wait_valid(output int at, output bit got);
    got = 0;
    at = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; at = cyc; break; end
    end
  endtask

  initial begin
    int  t1, t2, guard, target;
    bit  got;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_one(8'hFF, 8'hFF, 2'd2, 16'hFE01, 0, "ffxff");
    run_one(8'h00, 8'h37, 2'd1, 16'h0000, 0, "00x37");
    run_one(8'h01, 8'hA5, 2'd3, 16'h00A5, 0, "01xa5");
    run_one(8'h12, 8'h34, 2'd0, 16'h03A8, 10, "12x34 stall");

    // Back-to-back: second request waits on in_valid and is taken on the DONE handoff edge.
    @(posedge clk); #1;
    in_a = 8'h0F; in_b = 8'hF0; in_tag = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_a = 8'hAB; in_b = 8'hCD; in_tag = 2'd2;
    wait_valid(t1, got);
    check("b2b first valid", 32'(got), 32'(1));
    check("b2b first p", 32'(out_p), 32'(16'h0E10));
    check("b2b second ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(t2, got);
    check("b2b second valid", 32'(got), 32'(1));
    check("b2b second p", 32'(out_p), 32'(16'h88EF));
    check("b2b spacing", 32'(t2 - t1), 32'(5));
    @(posedge clk); #1;

    // Reset while S_LH is active.
    in_a = 8'h80; in_b = 8'h80; in_tag = 2'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'(0));
    check("midrst busy", 32'(busy), 32'(0));
    check("midrst out_p", 32'(out_p), 32'(0));
    check("midrst in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_one(8'h03, 8'h05, 2'd1, 16'h000F, 0, "03x05 after rst");

    // Random traffic with consumer stalls; the model checks products, tags and order.
    target = n_acc + 1000;
    guard = 0;
    while (n_acc < target && guard < 40000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      guard++;
    end
    check("random accepts", 32'(n_acc), 32'(target));
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    check("drain empty", 32'(q.size()), 32'(0));
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul8x8_seq.md
# mul8x8_seq

Area-reduced sequential 8x8 unsigned multiplier controller. It time-shares a single `mul4x4` instance across four partial-product steps and accumulates the result through a 16-bit `CLA`. It sits beside the combinational `mul8x8` as a drop-in alternative wherever a fixed 4-cycle latency is acceptable. Valid/ready handshakes are used on both the operand side and the result side.

## Interface
- `TAG_W`, default 2: width of the opaque request tag carried alongside the operands; must be ≥1.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: operand pair and tag present.
- `in_ready`  out  1: block can accept operands this cycle.
- `in_a`  in  8: multiplicand, unsigned.
- `in_b`  in  8: multiplier, unsigned.
- `in_tag`  in  TAG_W: request tag, returned unchanged.
- `out_valid`  out  1: product available.
- `out_ready`  in  1: consumer accepts product.
- `out_p`  out  16: product `in_a*in_b`.
- `out_tag`  out  TAG_W: tag of the product.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, S_LL, S_HL, S_LH, S_HH, DONE.
- Accept occurs on a clock edge with `in_valid && in_ready`. At accept, latch a, b and tag, clear the accumulator, and go to S_LL.
- Each step state drives the shared `mul4x4` with a nibble pair. At the edge the step ends, acc ← acc + (pp << shift).
  - S_LL: a[3:0]·b[3:0], shift 0.
  - S_HL: a[7:4]·b[3:0], shift 4.
  - S_LH: a[3:0]·b[7:4], shift 4.
  - S_HH: a[7:4]·b[7:4], shift 8.
- Step order is fixed: LL→HL→LH→HH→DONE.
- Arithmetic: the accumulator is 16 bits and the CLA carry-out is discarded. The maximum product 0xFE01 never overflows.
- There is no zero-operand shortcut. Latency is constant.
- DONE: `out_valid`=1 and `out_p`=acc.
  - `out_valid && out_ready` with no new accept → IDLE.
  - `out_valid && out_ready && in_valid` → S_LL, i.e. the result is handed off and the next request is accepted in the same edge.
  - Without `out_ready`, stay in DONE. `out_p` and `out_tag` hold stable.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from `out_ready`; no other combinational input→output paths exist.
- `in_valid` during S_LL..S_HH is ignored; `in_ready` is 0 in those states.
- Reset, including assertion mid-operation: state IDLE, acc 0, latched operands and tag 0. Outputs: `in_ready`=1, `out_valid`=0, `out_p`=0, `out_tag`=0, `busy`=0. The in-flight request is dropped with no partial output.

## Timing
- Accept at edge k. Steps complete at edges k+1..k+4. `out_valid` is high from edge k+4.
- Latency is 4 cycles, accept edge to `out_valid`.
- Throughput with `out_ready` held high and back-to-back requests: one result per 5 cycles.
- `out_valid` may stay high indefinitely. It never deasserts without an `out_ready` handshake or a reset.
- `busy` is registered from the state and is valid from the cycle after accept.

## Structure
- Shared package `mul_pkg` holds:
  - the state enum (IDLE, S_LL, S_HL, S_LH, S_HH, DONE);
  - step-to-shift constants (0, 4, 4, 8);
  - constants `MUL_OP_W`=8 and `MUL_P_W`=16.
- Sub-modules:
  - one instance of the existing `mul4x4`, with operand nibbles selected by state;
  - one `CLA #(.DATA_WIDTH(16))` with cin=0 for acc + shifted pp.
- No other hierarchy.

## Test plan
- 0xFF×0xFF, tag 2, `out_ready`=1 → `out_valid` exactly 4 cycles after accept, `out_p`=0xFE01, `out_tag`=2, then IDLE.
- 0x00×0x37 and 0x01×0xA5 → 0x0000 and 0x00A5, each after the same 4-cycle latency.
- 0x12×0x34 with `out_ready`=0 for 10 cycles → `out_valid` stays high, `out_p`=0x03A8 holds stable, `in_ready`=0; release `out_ready` → IDLE next edge.
- Back-to-back: 0x0F×0xF0 then 0xAB×0xCD, `in_valid` and `out_ready` held high → 0x0E10 then 0x88EF, second accept on the DONE edge, results 5 cycles apart.
- Assert `rst_n` low during S_LH of 0x80×0x80 → immediately `out_valid`=0, `busy`=0, `out_p`=0; after release, 0x03×0x05 → 0x000F with normal latency.
- Random 1000 operand pairs with random `out_ready` stalls → every `out_p` equals a*b and tags are returned in order.
